// File: rtl/mem_bus_arbiter_if.sv
// mem_bus_arbiter_if: bundles the fetch, data and memory-side handshake
// signals of the memory bus arbiter.
//   ifu_cmd_* / ifu_rsp_*  instruction-fetch port (read only)
//   lsu_cmd_* / lsu_rsp_*  load/store port (read or write)
//   mem_cmd_* / mem_rsp_*  shared memory bus, one transaction at a time
// Modports:
//   slave  - the arbiter's view (serves both requesters, drives memory)
//   master - the surrounding system's view (requesters plus memory)
interface mem_bus_arbiter_if;
    logic [31:0] ifu_cmd_addr;
    logic        ifu_cmd_valid;
    logic        ifu_cmd_ready;
    logic [31:0] ifu_rsp_rdata;
    logic        ifu_rsp_valid;

    logic [31:0] lsu_cmd_addr;
    logic [31:0] lsu_cmd_wdata;
    logic        lsu_cmd_we;
    logic        lsu_cmd_valid;
    logic        lsu_cmd_ready;
    logic [31:0] lsu_rsp_rdata;
    logic        lsu_rsp_valid;

    logic [31:0] mem_cmd_addr;
    logic [31:0] mem_cmd_wdata;
    logic        mem_cmd_we;
    logic        mem_cmd_valid;
    logic        mem_cmd_ready;
    logic [31:0] mem_rsp_rdata;
    logic        mem_rsp_valid;

    modport slave (
        input  ifu_cmd_addr, ifu_cmd_valid,
        output ifu_cmd_ready, ifu_rsp_rdata, ifu_rsp_valid,
        input  lsu_cmd_addr, lsu_cmd_wdata, lsu_cmd_we, lsu_cmd_valid,
        output lsu_cmd_ready, lsu_rsp_rdata, lsu_rsp_valid,
        output mem_cmd_addr, mem_cmd_wdata, mem_cmd_we, mem_cmd_valid,
        input  mem_cmd_ready, mem_rsp_rdata, mem_rsp_valid
    );

    modport master (
        output ifu_cmd_addr, ifu_cmd_valid,
        input  ifu_cmd_ready, ifu_rsp_rdata, ifu_rsp_valid,
        output lsu_cmd_addr, lsu_cmd_wdata, lsu_cmd_we, lsu_cmd_valid,
        input  lsu_cmd_ready, lsu_rsp_rdata, lsu_rsp_valid,
        input  mem_cmd_addr, mem_cmd_wdata, mem_cmd_we, mem_cmd_valid,
        output mem_cmd_ready, mem_rsp_rdata, mem_rsp_valid
    );
endinterface

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: shares one memory bus between the fetch port (ifu) and
// the load/store port (lsu). One transaction is outstanding at a time.
// lsu has fixed priority; a starvation counter forces an ifu grant after
// STARVE_LIMIT consecutive lsu grants taken while ifu was waiting.
// Ports:
//   clk   clock
//   rst   asynchronous active-high reset
//   bus   mem_bus_arbiter_if.slave (ifu, lsu and memory handshakes)
//   busy  transaction in flight (state != IDLE)
module mem_bus_arbiter #(
    parameter int STARVE_LIMIT = 4    // legal 1..15
) (
    input  logic                clk,
    input  logic                rst,
    mem_bus_arbiter_if.slave    bus,
    output logic                busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CMD  = 2'd1,
        RSP  = 2'd2
    } state_t;

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    state_t      state;
    state_t      state_nxt;
    logic        owner_lsu;     // 0 = ifu owns the bus, 1 = lsu
    logic [3:0]  starve_cnt;

    logic [31:0] cmd_addr;
    logic [31:0] cmd_wdata;
    logic        cmd_we;

    logic        starved;
    logic        grant_lsu;
    logic        grant_ifu;
    logic        rsp_fire;

    // Grants only exist in IDLE; rst gates them so no requester sees ready
    // while reset is asserted.
    always_comb begin
        starved   = bus.ifu_cmd_valid && (starve_cnt == LIMIT);
        grant_lsu = (state == IDLE) && !rst && bus.lsu_cmd_valid && !starved;
        grant_ifu = (state == IDLE) && !rst && bus.ifu_cmd_valid && !grant_lsu;
        rsp_fire  = (state == RSP) && !rst && bus.mem_rsp_valid;
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (grant_lsu || grant_ifu) state_nxt = CMD;
            CMD:  if (bus.mem_cmd_ready)      state_nxt = RSP;
            RSP:  if (bus.mem_rsp_valid)      state_nxt = IDLE;
            default:                          state_nxt = IDLE;
        endcase
    end

    // Outputs. Responses are forwarded only in RSP, so a stray mem_rsp_valid
    // in IDLE or CMD never reaches a requester.
    always_comb begin
        bus.ifu_cmd_ready = grant_ifu;
        bus.lsu_cmd_ready = grant_lsu;
        bus.ifu_rsp_valid = rsp_fire && !owner_lsu;
        bus.lsu_rsp_valid = rsp_fire &&  owner_lsu;
        bus.ifu_rsp_rdata = (rsp_fire && !owner_lsu) ? bus.mem_rsp_rdata : 32'h0;
        bus.lsu_rsp_rdata = (rsp_fire &&  owner_lsu) ? bus.mem_rsp_rdata : 32'h0;
        bus.mem_cmd_valid = (state == CMD);
        bus.mem_cmd_addr  = cmd_addr;
        bus.mem_cmd_wdata = cmd_wdata;
        bus.mem_cmd_we    = cmd_we;
        busy              = (state != IDLE);
    end

    // Command capture on the accept edge; held untouched through CMD/RSP.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cmd_addr  <= 32'h0;
            cmd_wdata <= 32'h0;
            cmd_we    <= 1'b0;
            owner_lsu <= 1'b0;
        end else if (grant_lsu) begin
            cmd_addr  <= bus.lsu_cmd_addr;
            cmd_wdata <= bus.lsu_cmd_wdata;
            cmd_we    <= bus.lsu_cmd_we;
            owner_lsu <= 1'b1;
        end else if (grant_ifu) begin
            cmd_addr  <= bus.ifu_cmd_addr;
            cmd_wdata <= 32'h0;
            cmd_we    <= 1'b0;
            owner_lsu <= 1'b0;
        end
    end

    // Starvation counter: counts lsu grants that overtook a waiting fetch,
    // saturating at the limit; any fetch grant clears it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            starve_cnt <= 4'd0;
        end else if (grant_ifu) begin
            starve_cnt <= 4'd0;
        end else if (grant_lsu && bus.ifu_cmd_valid && (starve_cnt != LIMIT)) begin
            starve_cnt <= starve_cnt + 4'd1;
        end
    end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
module tb_mem_bus_arbiter;

  logic clk = 1'b0;
  logic rst;
  logic busy;
  int   checks = 0;
  int   errors = 0;

  mem_bus_arbiter_if bus();

  mem_bus_arbiter #(.STARVE_LIMIT(4)) dut (
    .clk  (clk),
    .rst  (rst),
    .bus  (bus),
    .busy (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $error("FAIL %s got=%0h want=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [5:0] exp_lsu_win;
  int         exp_cnt [6];

  initial begin
    rst = 1'b1;
    bus.ifu_cmd_addr  = 32'h0;
    bus.ifu_cmd_valid = 1'b1;
    bus.lsu_cmd_addr  = 32'h0;
    bus.lsu_cmd_wdata = 32'h0;
    bus.lsu_cmd_we    = 1'b0;
    bus.lsu_cmd_valid = 1'b1;
    bus.mem_cmd_ready = 1'b0;
    bus.mem_rsp_rdata = 32'h0;
    bus.mem_rsp_valid = 1'b0;
    #2;
    chk("rst_busy",      busy,              1'b0);
    chk("rst_cmd_valid", bus.mem_cmd_valid, 1'b0);
    chk("rst_cmd_addr",  bus.mem_cmd_addr,  32'h0);
    chk("rst_ifu_ready", bus.ifu_cmd_ready, 1'b0);
    chk("rst_lsu_ready", bus.lsu_cmd_ready, 1'b0);
    chk("rst_cnt",       dut.starve_cnt,    4'd0);
    tick();
    tick();
    rst = 1'b0;
    bus.ifu_cmd_valid = 1'b0;
    bus.lsu_cmd_valid = 1'b0;

    tick();
    bus.ifu_cmd_valid = 1'b1;
    bus.ifu_cmd_addr  = 32'h100;
    bus.mem_cmd_ready = 1'b1;
    #1;
    chk("rd_ifu_ready", bus.ifu_cmd_ready, 1'b1);
    chk("rd_lsu_ready", bus.lsu_cmd_ready, 1'b0);
    tick();
    bus.ifu_cmd_valid = 1'b0;
    #1;
    chk("rd_cmd_valid", bus.mem_cmd_valid, 1'b1);
    chk("rd_cmd_addr",  bus.mem_cmd_addr,  32'h100);
    chk("rd_cmd_we",    bus.mem_cmd_we,    1'b0);
    chk("rd_busy",      busy,              1'b1);
    tick();
    bus.mem_rsp_valid = 1'b1;
    bus.mem_rsp_rdata = 32'hDEADBEEF;
    #1;
    chk("rd_cmd_drop",  bus.mem_cmd_valid, 1'b0);
    chk("rd_ifu_rsp",   bus.ifu_rsp_valid, 1'b1);
    chk("rd_ifu_rdata", bus.ifu_rsp_rdata, 32'hDEADBEEF);
    chk("rd_lsu_rsp",   bus.lsu_rsp_valid, 1'b0);
    chk("rd_lsu_rdata", bus.lsu_rsp_rdata, 32'h0);
    tick();
    bus.mem_rsp_valid = 1'b0;
    #1;
    chk("rd_idle", busy, 1'b0);

    bus.lsu_cmd_valid = 1'b1;
    bus.lsu_cmd_addr  = 32'h2000;
    bus.lsu_cmd_wdata = 32'h12345678;
    bus.lsu_cmd_we    = 1'b1;
    bus.mem_cmd_ready = 1'b0;
    #1;
    chk("wr_lsu_ready", bus.lsu_cmd_ready, 1'b1);
    tick();
    bus.lsu_cmd_valid = 1'b0;
    bus.lsu_cmd_addr  = 32'hFFFF_0000;
    bus.lsu_cmd_wdata = 32'h0;
    bus.lsu_cmd_we    = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (i == 3) bus.mem_cmd_ready = 1'b1;
      #1;
      chk("wr_hold_valid", bus.mem_cmd_valid, 1'b1);
      chk("wr_hold_addr",  bus.mem_cmd_addr,  32'h2000);
      chk("wr_hold_wdata", bus.mem_cmd_wdata, 32'h12345678);
      chk("wr_hold_we",    bus.mem_cmd_we,    1'b1);
      tick();
    end
    bus.mem_rsp_valid = 1'b1;
    bus.mem_rsp_rdata = 32'h0;
    #1;
    chk("wr_ack",     bus.lsu_rsp_valid, 1'b1);
    chk("wr_ack_ifu", bus.ifu_rsp_valid, 1'b0);
    tick();
    bus.mem_rsp_valid = 1'b0;
    #1;
    chk("wr_busy_after", busy,              1'b0);
    chk("wr_ack_once",   bus.lsu_rsp_valid, 1'b0);
    chk("wr_cnt",        dut.starve_cnt,    4'd0);

    bus.ifu_cmd_valid = 1'b1;
    bus.ifu_cmd_addr  = 32'h300;
    bus.lsu_cmd_valid = 1'b1;
    bus.lsu_cmd_addr  = 32'h400;
    bus.lsu_cmd_we    = 1'b0;
    bus.mem_cmd_ready = 1'b1;
    #1;
    chk("sim_lsu_ready", bus.lsu_cmd_ready, 1'b1);
    chk("sim_ifu_ready", bus.ifu_cmd_ready, 1'b0);
    tick();
    bus.lsu_cmd_valid = 1'b0;
    #1;
    chk("sim_addr_lsu",   bus.mem_cmd_addr,  32'h400);
    chk("sim_ifu_wait_c", bus.ifu_cmd_ready, 1'b0);
    tick();
    bus.mem_rsp_valid = 1'b1;
    bus.mem_rsp_rdata = 32'h55;
    #1;
    chk("sim_lsu_rsp",    bus.lsu_rsp_rdata, 32'h55);
    chk("sim_ifu_wait_r", bus.ifu_cmd_ready, 1'b0);
    tick();
    bus.mem_rsp_valid = 1'b0;
    #1;
    chk("sim_ifu_ready2", bus.ifu_cmd_ready, 1'b1);
    chk("sim_cnt1",       dut.starve_cnt,    4'd1);
    tick();
    bus.ifu_cmd_valid = 1'b0;
    #1;
    chk("sim_addr_ifu", bus.mem_cmd_addr, 32'h300);
    tick();
    bus.mem_rsp_valid = 1'b1;
    tick();
    bus.mem_rsp_valid = 1'b0;
    #1;
    chk("sim_cnt0", dut.starve_cnt, 4'd0);

    exp_lsu_win = 6'b101111;
    exp_cnt     = '{0, 1, 2, 3, 4, 0};
    bus.ifu_cmd_valid = 1'b1;
    bus.ifu_cmd_addr  = 32'h500;
    bus.lsu_cmd_valid = 1'b1;
    bus.lsu_cmd_addr  = 32'h600;
    for (int k = 0; k < 6; k++) begin
      #1;
      chk("stv_cnt",       dut.starve_cnt,    4'(exp_cnt[k]));
      chk("stv_lsu_ready", bus.lsu_cmd_ready, exp_lsu_win[k]);
      chk("stv_ifu_ready", bus.ifu_cmd_ready, !exp_lsu_win[k]);
      tick();
      #1;
      chk("stv_addr", bus.mem_cmd_addr, exp_lsu_win[k] ? 32'h600 : 32'h500);
      tick();
      bus.mem_rsp_valid = 1'b1;
      tick();
      bus.mem_rsp_valid = 1'b0;
    end
    bus.ifu_cmd_valid = 1'b0;
    bus.lsu_cmd_valid = 1'b0;
    #1;
    chk("stv_cnt_end", dut.starve_cnt, 4'd1);

    bus.mem_rsp_valid = 1'b1;
    bus.mem_rsp_rdata = 32'hBAD;
    #1;
    chk("sp_idle_ifu", bus.ifu_rsp_valid, 1'b0);
    chk("sp_idle_lsu", bus.lsu_rsp_valid, 1'b0);
    tick();
    chk("sp_idle_busy", busy, 1'b0);
    bus.mem_rsp_valid = 1'b0;
    bus.mem_cmd_ready = 1'b0;
    bus.ifu_cmd_valid = 1'b1;
    bus.ifu_cmd_addr  = 32'h700;
    tick();
    bus.ifu_cmd_valid = 1'b0;
    bus.mem_rsp_valid = 1'b1;
    #1;
    chk("sp_cmd_ifu", bus.ifu_rsp_valid, 1'b0);
    tick();
    chk("sp_cmd_wait", bus.mem_cmd_valid, 1'b1);
    bus.mem_rsp_valid = 1'b0;
    bus.mem_cmd_ready = 1'b1;
    tick();
    #1;
    chk("rr_in_rsp", busy, 1'b1);

    bus.ifu_cmd_valid = 1'b1;
    bus.ifu_cmd_addr  = 32'h800;
    bus.mem_rsp_valid = 1'b1;
    bus.mem_rsp_rdata = 32'hCAFE;
    rst = 1'b1;
    #1;
    chk("rr_busy",      busy,              1'b0);
    chk("rr_cmd_valid", bus.mem_cmd_valid, 1'b0);
    chk("rr_ifu_ready", bus.ifu_cmd_ready, 1'b0);
    chk("rr_ifu_rsp",   bus.ifu_rsp_valid, 1'b0);
    tick();
    rst = 1'b0;
    bus.mem_rsp_valid = 1'b0;
    #1;
    chk("rr_new_ready", bus.ifu_cmd_ready, 1'b1);
    tick();
    bus.ifu_cmd_valid = 1'b0;
    #1;
    chk("rr_new_addr", bus.mem_cmd_addr, 32'h800);
    tick();
    bus.mem_rsp_valid = 1'b1;
    #1;
    chk("rr_new_rdata", bus.ifu_rsp_rdata, 32'hCAFE);
    tick();
    bus.mem_rsp_valid = 1'b0;
    #1;
    chk("rr_new_idle", busy, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
- Shares one memory bus between the instruction-fetch port (ifu) and the execution unit's data port (lsu).
- Sits between the core and the memory/interconnect.
- Carries exactly one outstanding transaction at a time.
- Uses fixed lsu priority, with a starvation limiter that guarantees fetch progress.

Parameters:
- STARVE_LIMIT, 4, max consecutive lsu grants while ifu is pending; legal 1..15.

Ports:
- clk  in  1  clock; single clock domain.
- rst  in  1  reset; asynchronous, active-high.
- ifu_cmd_addr  in  32  fetch address (read only).
- ifu_cmd_valid  in  1  fetch request.
- ifu_cmd_ready  out  1  fetch request accepted this cycle.
- ifu_rsp_rdata  out  32  fetch read data.
- ifu_rsp_valid  out  1  fetch response strobe.
- lsu_cmd_addr  in  32  data address.
- lsu_cmd_wdata  in  32  store data.
- lsu_cmd_we  in  1  1 = write, 0 = read.
- lsu_cmd_valid  in  1  data request.
- lsu_cmd_ready  out  1  data request accepted this cycle.
- lsu_rsp_rdata  out  32  load data.
- lsu_rsp_valid  out  1  data response strobe; also the write ack.
- mem_cmd_addr  out  32  registered command address.
- mem_cmd_wdata  out  32  registered write data.
- mem_cmd_we  out  1  registered write enable.
- mem_cmd_valid  out  1  command valid.
- mem_cmd_ready  in  1  memory accepts command.
- mem_rsp_rdata  in  32  memory read data.
- mem_rsp_valid  in  1  memory response; one per command, writes included.
- busy  out  1  transaction in flight (state != IDLE).

Behaviour:
- Reset: one clock, asynchronous active-high reset.
  - On reset: state=IDLE, owner=IFU, starve_cnt=0.
  - mem_cmd_addr/wdata=0, mem_cmd_we=0, mem_cmd_valid=0, busy=0.
  - All *_cmd_ready and *_rsp_valid are 0 while rst is high.
- FSM states:
  - IDLE: no transaction.
  - CMD: mem_cmd_valid=1, holding the registered command.
  - RSP: waiting for mem_rsp_valid.
- IDLE grant (combinational):
  - grant_lsu = lsu_cmd_valid && !(ifu_cmd_valid && starve_cnt==STARVE_LIMIT).
  - grant_ifu = ifu_cmd_valid && !grant_lsu.
  - The granted port sees *_cmd_ready=1 in the same cycle.
  - *_cmd_ready is 0 in all non-IDLE states.
- On a grant edge:
  - Command is captured into mem_cmd_*. For ifu, we=0 and wdata=0.
  - owner is set; state -> CMD, so mem_cmd_valid rises 1 cycle after the accept.
- CMD:
  - Hold all mem_cmd_* stable until mem_cmd_ready=1.
  - On that edge: mem_cmd_valid -> 0, state -> RSP.
- RSP:
  - mem_rsp_valid=1 gives owner's *_rsp_valid=1 in the same cycle, combinational.
  - owner's *_rsp_rdata = mem_rsp_rdata; state -> IDLE next edge.
  - The non-owner's rsp_valid stays 0, rdata 0.
- mem_rsp_valid outside RSP (IDLE/CMD): ignored, not forwarded.
- Minimum transaction period: 3 cycles (accept, cmd handshake, rsp). No grant in the response cycle.
- Starvation counter:
  - +1 on an lsu grant while ifu_cmd_valid=1, saturating at STARVE_LIMIT.
  - Cleared to 0 on any ifu grant.
  - Unchanged on an lsu grant with ifu idle.
- Simultaneous requests with starve_cnt<STARVE_LIMIT: lsu wins.
- Simultaneous requests with starve_cnt==STARVE_LIMIT: ifu wins, counter clears.
- Requester contract: address/data held stable while *_cmd_valid=1 and not accepted. Dropping valid before accept is permitted; the request is then simply not granted.
- Reset mid-transaction: FSM returns to IDLE and the in-flight transaction is dropped. Memory must be reset by the same rst so no stale response arrives.
- busy = (state != IDLE).

Test Plan:
- Single ifu read:
  - Stimulus: ifu_cmd_valid=1, addr=0x100. Memory has ready=1 and returns rdata=0xDEADBEEF 2 cycles later.
  - Required: ifu_cmd_ready at c0, mem_cmd_valid at c1 with addr=0x100 we=0, ifu_rsp_valid=1 with 0xDEADBEEF, lsu_rsp_valid stays 0.
- lsu write with backpressure:
  - Stimulus: addr=0x2000, wdata=0x12345678, we=1; mem_cmd_ready held low 3 cycles.
  - Required: mem_cmd_* stable for 4 cycles; lsu_rsp_valid pulses once on the ack; busy=0 the cycle after.
- Simultaneous requests, counter 0:
  - Stimulus: ifu and lsu both valid.
  - Required: lsu granted first; ifu_cmd_ready=0 until the lsu transaction completes; then ifu granted.
- Starvation, STARVE_LIMIT=4:
  - Stimulus: lsu and ifu held valid continuously.
  - Required: grant order lsu, lsu, lsu, lsu, ifu, then lsu; starve_cnt reads 4 before the ifu grant and 0 after.
- Spurious response:
  - Stimulus: mem_rsp_valid=1 while IDLE and while in CMD.
  - Required: no *_rsp_valid asserted; state unchanged in IDLE; CMD still waits for mem_cmd_ready.
- Reset mid-operation:
  - Stimulus: assert rst asynchronously in RSP.
  - Required: mem_cmd_valid=0, busy=0, all ready/rsp_valid=0 immediately. After release, a new ifu request is granted normally.
